hazard_ctrl: RTL and testbench

Pipeline stall/flush controller for the five-stage core. Sits beside the ID stage and decides each cycle which stages hold and which receive bubbles. Its inputs are ID register-read requests, a shadow of the load instruction currently in EX, the EX multicycle busy flag, the MEM wait request and the flush request. It also runs a watchdog on EX busy stalls and, optionally, per-cause stall counters.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_sat_cnt.sv | 19 +
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl shared definitions: stall-bit indices, FSM states, stall masks.
// Counter ports and logic exist only when HAZARD_STATS_EN is defined.
package hazard_ctrl_pkg;

    localparam int ST_PC  = 0;
    localparam int ST_IF  = 1;
    localparam int ST_ID  = 2;
    localparam int ST_EX  = 3;
    localparam int ST_MEM = 4;
    localparam int ST_WB  = 5;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LU   = 2'd1,
        EXW  = 2'd2,
        MEMW = 2'd3
    } state_e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM requests in, stall/flush controls out.
// Counter signals exist only when HAZARD_STATS_EN is defined.
interface hazard_ctrl_if;

    logic       id_inst_vld_i;
    logic       id_reg1_ren_i;
    logic       id_reg2_ren_i;
    logic [4:0] id_reg1_addr_i;
    logic [4:0] id_reg2_addr_i;
    logic       id_wreg_i;
    logic [4:0] id_waddr_i;
    logic       id_is_load_i;
    logic       ex_busy_i;
    logic       mem_stallreq_i;
    logic       flush_i;
    logic [5:0] stall_o;
    logic       flush_o;
    logic [1:0] cause_o;
    logic       ex_timeout_o;
`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt_o;
    logic [31:0] ex_cnt_o;
    logic [31:0] mem_cnt_o;
`endif

    modport master (
        output id_inst_vld_i, id_reg1_ren_i, id_reg2_ren_i,
        output id_reg1_addr_i, id_reg2_addr_i,
        output id_wreg_i, id_waddr_i, id_is_load_i,
        output ex_busy_i, mem_stallreq_i, flush_i,
`ifdef HAZARD_STATS_EN
        input  lu_cnt_o, ex_cnt_o, mem_cnt_o,
`endif
        input  stall_o, flush_o, cause_o, ex_timeout_o
    );

    modport slave (
        input  id_inst_vld_i, id_reg1_ren_i, id_reg2_ren_i,
        input  id_reg1_addr_i, id_reg2_addr_i,
        input  id_wreg_i, id_waddr_i, id_is_load_i,
        input  ex_busy_i, mem_stallreq_i, flush_i,
`ifdef HAZARD_STATS_EN
        output lu_cnt_o, ex_cnt_o, mem_cnt_o,
`endif
        output stall_o, flush_o, cause_o, ex_timeout_o
    );

endinterface

// File: rtl/hazard_sat_cnt.sv
// 32-bit saturating event counter with enable and synchronous reset.
// Built only with HAZARD_STATS_EN, the sole configuration that uses it.
`ifdef HAZARD_STATS_EN
module hazard_sat_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (en && cnt != 32'hFFFF_FFFF)
            cnt <= cnt + 32'd1;
    end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use shadow, cause priority, EX watchdog.
// Define HAZARD_STATS_EN to add per-cause saturating stall counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_EX_WAIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    state_e      state;
    state_e      nxt;
    logic        ex_ld_vld;
    logic [4:0]  ex_ld_addr;
    logic [15:0] ex_wait;
    logic [15:0] ex_wait_nx;
    logic        timeout;
    logic        r1_hit;
    logic        r2_hit;
    logic        lu_hz;
    logic        ld_new;
    logic        c_fl;
    logic        c_mem;
    logic        c_ex;
    logic        c_lu;
    logic [5:0]  stall;
    logic        flush;

    assign r1_hit = hz.id_reg1_ren_i && (hz.id_reg1_addr_i != 5'd0)
                 && (hz.id_reg1_addr_i == ex_ld_addr);
    assign r2_hit = hz.id_reg2_ren_i && (hz.id_reg2_addr_i != 5'd0)
                 && (hz.id_reg2_addr_i == ex_ld_addr);
    assign lu_hz  = ex_ld_vld && (r1_hit || r2_hit);

    assign ld_new = hz.id_inst_vld_i && hz.id_is_load_i
                 && hz.id_wreg_i && (hz.id_waddr_i != 5'd0);

    // One-hot applied cause, priority flush > MEM > EX > load-use
    assign c_fl  = hz.flush_i;
    assign c_mem = !c_fl && hz.mem_stallreq_i;
    assign c_ex  = !c_fl && !hz.mem_stallreq_i && hz.ex_busy_i;
    assign c_lu  = !c_fl && !hz.mem_stallreq_i && !hz.ex_busy_i && lu_hz;

    always_comb begin
        stall = STALL_NONE;
        flush = 1'b0;
        nxt   = RUN;
        unique case (1'b1)
            c_fl:  flush = 1'b1;
            c_mem: begin stall = STALL_MEM; nxt = MEMW; end
            c_ex:  begin stall = STALL_EX;  nxt = EXW;  end
            c_lu:  begin stall = STALL_LU;  nxt = LU;   end
            default: ;
        endcase
    end

    assign hz.stall_o      = rst ? STALL_NONE : stall;
    assign hz.flush_o      = !rst && flush;
    assign hz.cause_o      = state;
    assign hz.ex_timeout_o = timeout;

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= nxt;
    end

    // Shadow follows whatever enters EX: held, bubbled or newly loaded
    always_ff @(posedge clk) begin
        if (rst || c_fl) begin
            ex_ld_vld  <= 1'b0;
            ex_ld_addr <= 5'd0;
        end else if (stall[ST_EX]) begin
            ex_ld_vld  <= ex_ld_vld;
            ex_ld_addr <= ex_ld_addr;
        end else if (stall[ST_ID]) begin
            ex_ld_vld  <= 1'b0;
            ex_ld_addr <= 5'd0;
        end else begin
            ex_ld_vld  <= ld_new;
            ex_ld_addr <= hz.id_waddr_i;
        end
    end

    assign ex_wait_nx = (ex_wait == 16'hFFFF) ? ex_wait : ex_wait + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_wait <= 16'd0;
            timeout <= 1'b0;
        end else if (c_ex) begin
            ex_wait <= ex_wait_nx;
            if (ex_wait_nx == 16'(MAX_EX_WAIT))
                timeout <= 1'b1;
        end else begin
            ex_wait <= 16'd0;
        end
    end

`ifdef HAZARD_STATS_EN
    hazard_sat_cnt u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .en  (c_lu),
        .cnt (hz.lu_cnt_o)
    );

    hazard_sat_cnt u_ex_cnt (
        .clk (clk),
        .rst (rst),
        .en  (c_ex),
        .cnt (hz.ex_cnt_o)
    );

    hazard_sat_cnt u_mem_cnt (
        .clk (clk),
        .rst (rst),
        .en  (c_mem),
        .cnt (hz.mem_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic.
// Expectations come from a cause-level reference model; HAZARD_STATS_EN adds counter checks.
module tb_hazard_ctrl;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MAX_EX_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       rst;
        bit       flush;
        bit       mem;
        bit       busy;
        bit       vld;
        bit       ld;
        bit       wr;
        bit [4:0] wa;
        bit       r1e;
        bit [4:0] r1a;
        bit       r2e;
        bit [4:0] r2a;
    } stim_t;

    typedef struct {
        logic [5:0] stall;
        logic       fl;
        logic [1:0] cause;
        logic       to;
        longint     lu;
        longint     ex;
        longint     mem;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    bit       m_ldv;
    bit [4:0] m_lda;
    int       m_run;
    bit       m_to;
    int       m_st;
    longint   m_lu, m_ex, m_mem;

    function automatic void m_reset();
        m_ldv = 0; m_lda = 0; m_run = 0; m_to = 0; m_st = 0;
        m_lu = 0;  m_ex = 0;  m_mem = 0;
    endfunction

    function automatic longint sat(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        exp_t    e;
        bit      haz;
        string   kind;
        @(posedge clk);
        #1;
        rst               = s.rst;
        hz.flush_i        = s.flush;
        hz.mem_stallreq_i = s.mem;
        hz.ex_busy_i      = s.busy;
        hz.id_inst_vld_i  = s.vld;
        hz.id_is_load_i   = s.ld;
        hz.id_wreg_i      = s.wr;
        hz.id_waddr_i     = s.wa;
        hz.id_reg1_ren_i  = s.r1e;
        hz.id_reg1_addr_i = s.r1a;
        hz.id_reg2_ren_i  = s.r2e;
        hz.id_reg2_addr_i = s.r2a;

        haz = m_ldv && m_lda != 0 &&
              ((s.r1e && s.r1a == m_lda) || (s.r2e && s.r2a == m_lda));
        if (s.flush)     kind = "F";
        else if (s.mem)  kind = "M";
        else if (s.busy) kind = "E";
        else if (haz)    kind = "L";
        else             kind = "N";

        e.fl    = (!s.rst && kind == "F");
        e.stall = s.rst ? 6'd0 :
                  (kind == "M") ? 6'b011111 :
                  (kind == "E") ? 6'b001111 :
                  (kind == "L") ? 6'b000111 : 6'd0;
        e.cause = m_st[1:0];
        e.to    = m_to;
        e.lu    = m_lu;
        e.ex    = m_ex;
        e.mem   = m_mem;
        sbq.push_back(e);

        if (s.rst) begin
            m_reset();
        end else begin
            m_st = (kind == "L") ? 1 : (kind == "E") ? 2 : (kind == "M") ? 3 : 0;
            if (kind == "F" || kind == "L") begin
                m_ldv = 0; m_lda = 0;
            end else if (kind == "N") begin
                m_ldv = s.vld && s.ld && s.wr && s.wa != 0;
                m_lda = s.wa;
            end
            if (kind == "E") begin
                if (m_run < 65535) m_run++;
                if (m_run == MAXW) m_to = 1;
            end else begin
                m_run = 0;
            end
            if (kind == "L") m_lu  = sat(m_lu);
            if (kind == "E") m_ex  = sat(m_ex);
            if (kind == "M") m_mem = sat(m_mem);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stall_o", 64'(hz.stall_o), 64'(e.stall));
                chk("flush_o", 64'(hz.flush_o), 64'(e.fl));
                chk("cause_o", 64'(hz.cause_o), 64'(e.cause));
                chk("ex_timeout_o", 64'(hz.ex_timeout_o), 64'(e.to));
`ifdef HAZARD_STATS_EN
                chk("lu_cnt_o", 64'(hz.lu_cnt_o), 64'(e.lu));
                chk("ex_cnt_o", 64'(hz.ex_cnt_o), 64'(e.ex));
                chk("mem_cnt_o", 64'(hz.mem_cnt_o), 64'(e.mem));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t load(input bit [4:0] a);
        stim_t s;
        s = '0;
        s.vld = 1; s.ld = 1; s.wr = 1; s.wa = a;
        return s;
    endfunction

    function automatic stim_t use2(input bit [4:0] a);
        stim_t s;
        s = '0;
        s.vld = 1; s.r2e = 1; s.r2a = a;
        return s;
    endfunction

    bit [4:0] regs [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5};

    initial begin
        stim_t s;
        int    busy_left;
        m_reset();
        hz.flush_i = 0; hz.mem_stallreq_i = 0; hz.ex_busy_i = 0;
        hz.id_inst_vld_i = 0; hz.id_is_load_i = 0; hz.id_wreg_i = 0;
        hz.id_waddr_i = 0; hz.id_reg1_ren_i = 0; hz.id_reg1_addr_i = 0;
        hz.id_reg2_ren_i = 0; hz.id_reg2_addr_i = 0;

        s = idle(); s.rst = 1;
        drive(s); drive(s);
        drive(idle());

        // load r5 then use on port 2
        drive(load(5)); drive(use2(5)); drive(use2(5)); drive(idle());
        // load r0 then use r0
        drive(load(0)); drive(use2(0)); drive(idle());
        // hazard pending behind 3 EX-busy cycles
        drive(load(5));
        s = use2(5); s.busy = 1;
        drive(s); drive(s); drive(s);
        drive(use2(5)); drive(use2(5)); drive(idle());
        // flush wins over MEM and clears shadow
        drive(load(3));
        s = use2(3); s.mem = 1; s.flush = 1;
        drive(s); drive(use2(3)); drive(idle());
        // watchdog: 6 busy cycles, sticky until rst
        s = idle(); s.busy = 1;
        repeat (6) drive(s);
        drive(idle()); drive(idle());
        s = idle(); s.rst = 1; drive(s);
        drive(idle());
        // counter sequence with mid-sequence rst
        drive(load(2)); drive(use2(2));
        drive(load(1)); drive(use2(1));
        s = idle(); s.busy = 1; repeat (5) drive(s);
        s = idle(); s.mem = 1;  repeat (3) drive(s);
        drive(idle());
        s = idle(); s.rst = 1; drive(s);
        drive(idle());

        busy_left = 0;
        repeat (3000) begin
            s = '0;
            s.rst   = ($urandom_range(99) < 2);
            s.flush = ($urandom_range(99) < 4);
            s.mem   = ($urandom_range(99) < 10);
            if (busy_left > 0) begin
                s.busy = 1; busy_left--;
            end else if ($urandom_range(99) < 8) begin
                busy_left = $urandom_range(6, 1);
            end
            s.vld = ($urandom_range(99) < 80);
            s.ld  = ($urandom_range(1) == 1);
            s.wr  = ($urandom_range(99) < 80);
            s.wa  = regs[$urandom_range(4)];
            s.r1e = ($urandom_range(99) < 70);
            s.r1a = regs[$urandom_range(4)];
            s.r2e = ($urandom_range(99) < 70);
            s.r2a = regs[$urandom_range(4)];
            drive(s);
        end

        drive(idle());
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
